l_fifo: RTL and testbench
=========================

# l_fifo

Single-clock first-in/first-out byte buffer, 2048 entries × 8 bits, with full, empty, almost-full and almost-empty status flags. It decouples a producer and a consumer that share one clock domain. Storage is an inferred synchronous block RAM. The block has no global-reset input; all initialisation comes from `rst`.

## Interface
Parameters:
- `DEPTH_WIDTH`, 11 — address width; depth = 2^DEPTH_WIDTH = 2048 entries.
- `DATA_WIDTH`, 8 — width of the write and read data.
- `ALMOST_FULL_NUM`, 1020 — occupancy threshold for `almost_full`.
- `ALMOST_EMPTY_NUM`, 4 — occupancy threshold for `almost_empty`.

Ports:
- `clk` — in, 1 — single clock; all logic is on the rising edge.
- `rst` — in, 1 — reset is synchronous and active-high.
- `wr_data` — in, DATA_WIDTH — data to be written.
- `wr_en` — in, 1 — write request.
- `wr_full` — out, 1 — FIFO holds 2048 entries.
- `almost_full` — out, 1 — occupancy ≥ ALMOST_FULL_NUM.
- `rd_data` — out, DATA_WIDTH — read data, registered.
- `rd_en` — in, 1 — read request.
- `rd_empty` — out, 1 — FIFO holds 0 entries.
- `almost_empty` — out, 1 — occupancy ≤ ALMOST_EMPTY_NUM.

## Operation
- State:
  - write pointer `wp` and read pointer `rp`, each DEPTH_WIDTH+1 bits.
  - occupancy `cnt`, DEPTH_WIDTH+1 bits, range 0..2048.
- Accept rules, evaluated on pre-edge flags:
  - `wr_acc = wr_en & ~wr_full`
  - `rd_acc = rd_en & ~rd_empty`
- Write: on `wr_acc`, store `wr_data` at `mem[wp[DEPTH_WIDTH-1:0]]`, then `wp <= wp + 1`.
- Read: on `rd_acc`, `rd_data <= mem[rp[DEPTH_WIDTH-1:0]]`, then `rp <= rp + 1`.
  - When no read is accepted, `rd_data` holds its last value.
- Occupancy: `cnt <= cnt + wr_acc - rd_acc`.
  - Pointers wrap naturally modulo 2^(DEPTH_WIDTH+1).
  - Memory index wraps modulo 2048.
- Rejected requests:
  - A write while full is dropped silently: no pointer change, no memory change.
  - A read while empty is dropped silently: `rd_data` is unchanged.
- Simultaneous requests:
  - Simultaneous write and read, neither flag set: both proceed and `cnt` is unchanged.
  - Simultaneous write and read when empty: only the write is accepted.
  - Simultaneous write and read when full: only the read is accepted.
- Flags are registered. They are computed from the next value of `cnt` so they are exact in the cycle after the edge:
  - `wr_full = (cnt_next == 2048)`
  - `rd_empty = (cnt_next == 0)`
  - `almost_full = (cnt_next >= ALMOST_FULL_NUM)`
  - `almost_empty = (cnt_next <= ALMOST_EMPTY_NUM)`
- No overflow or underflow error outputs.

## Timing
- Reset: while `rst` = 1 at a rising edge, the following take these values; memory contents are not cleared.
  - `wp`, `rp`, `cnt` = 0
  - `rd_data` = 0
  - `rd_empty` = 1, `almost_empty` = 1
  - `wr_full` = 0, `almost_full` = 0
- Reset mid-operation discards all contents and takes priority over any `wr_en`/`rd_en` in the same cycle.
- Read latency: with `rd_en` = 1 and the FIFO non-empty at edge N, the data is valid on `rd_data` after edge N, during cycle N+1. There is no extra output register.
- Back-to-back reads give one new word per cycle.
- Write-to-read: a word written at edge N makes `rd_empty` = 0 after edge N. It can be read at edge N+1 and appears on `rd_data` after N+1.
- Flag updates: all four flags change on the same edge as `cnt`.

## Test plan
- Reset: hold `rst` for 20 cycles -> `rd_empty` = 1, `almost_empty` = 1, `wr_full` = 0, `almost_full` = 0, `rd_data` = 0x00.
- Fill: assert `wr_en` for 2049 consecutive cycles with data 0xFF, 0xFE, … (decrementing, wrapping mod 256).
  - `almost_empty` drops once occupancy reaches 5.
  - `almost_full` rises at occupancy 1020.
  - `wr_full` rises after the 2048th write.
  - The 2049th write (0xFF) is dropped.
- Drain: after the fill, assert `rd_en` for 2049 cycles.
  - `rd_data` shows 0xFF one cycle after the first `rd_en`, then 0xFE, 0xFD, …, with 2048 words total matching the write order.
  - The 2049th read is rejected and `rd_data` holds 0x00.
  - `rd_empty` = 1 at the end.
  - Zero mismatches.
- Read on empty: `rd_en` = 1 after reset -> no change to `rd_data`, `rd_empty` stays 1, pointers unchanged.
- Concurrent: preload 10 words, then apply `wr_en` and `rd_en` together for 100 cycles -> occupancy stays at 10, all flags steady, data stays in order.
- Boundaries:
  - With the FIFO full, read and write in the same cycle -> read accepted, write dropped, `cnt` = 2047.
  - With the FIFO empty, read and write in the same cycle -> write accepted, `cnt` = 1.
  - `rst` asserted while half-full -> empty on the next cycle.

Source files
------------

// File: rtl/l_fifo.sv
// l_fifo: single-clock byte FIFO with full/empty and almost-full/almost-empty
// status. Storage is a synchronous RAM that is never cleared. Reset only
// reinitialises the pointers, the occupancy count, the read register and
// the flags.
module l_fifo #(
    parameter int DEPTH_WIDTH      = 11,
    parameter int DATA_WIDTH       = 8,
    parameter int ALMOST_FULL_NUM  = 1020,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic                  wr_full,
    output logic                  almost_full,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_en,
    output logic                  rd_empty,
    output logic                  almost_empty
);
    localparam int DEPTH = 1 << DEPTH_WIDTH;
    localparam int PW    = DEPTH_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wp_q, rp_q, cnt_q;
    logic [PW-1:0]         wp_d, rp_d, cnt_d;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  full_q, afull_q, empty_q, aempty_q;
    logic                  wr_acc, rd_acc;

    // Requests are gated by the registered flags, which already reflect the
    // current occupancy, so no request can overflow or underflow the buffer.
    assign wr_acc = wr_en & ~full_q;
    assign rd_acc = rd_en & ~empty_q;

    // Next-state pointers and occupancy; pointers wrap naturally.
    always_comb begin
        wp_d  = wp_q + PW'(wr_acc);
        rp_d  = rp_q + PW'(rd_acc);
        cnt_d = cnt_q + PW'(wr_acc) - PW'(rd_acc);
    end

    // RAM write port; kept reset-free so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_acc && !rst)
            mem_q[wp_q[DEPTH_WIDTH-1:0]] <= wr_data;
    end

    // Registered RAM read port; holds its value when no read is accepted.
    always_ff @(posedge clk) begin
        if (rst)
            rd_data_q <= '0;
        else if (rd_acc)
            rd_data_q <= mem_q[rp_q[DEPTH_WIDTH-1:0]];
    end

    // Pointers, occupancy and flags. Flags are derived from the next count
    // so they are exact in the cycle following each edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q     <= '0;
            rp_q     <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            empty_q  <= 1'b1;
            aempty_q <= 1'b1;
        end else begin
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            cnt_q    <= cnt_d;
            full_q   <= (cnt_d == PW'(DEPTH));
            afull_q  <= (cnt_d >= PW'(ALMOST_FULL_NUM));
            empty_q  <= (cnt_d == '0);
            aempty_q <= (cnt_d <= PW'(ALMOST_EMPTY_NUM));
        end
    end

    assign rd_data      = rd_data_q;
    assign wr_full      = full_q;
    assign almost_full  = afull_q;
    assign rd_empty     = empty_q;
    assign almost_empty = aempty_q;

endmodule

// File: tb/tb_l_fifo.sv
// Directed bench for l_fifo: reset, empty read, full fill/drain,
// concurrent traffic and the full/empty/reset boundaries.
module tb_l_fifo;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       wr_full;
    logic       almost_full;
    logic [7:0] rd_data;
    logic       rd_en;
    logic       rd_empty;
    logic       almost_empty;

    int compared = 0;
    int mismatched = 0;

    // Reference contents and the read value expected on rd_data.
    logic [7:0] q[$];
    logic [7:0] exp_rd;

    l_fifo dut (
        .clk          (clk),
        .rst          (rst),
        .wr_data      (wr_data),
        .wr_en        (wr_en),
        .wr_full      (wr_full),
        .almost_full  (almost_full),
        .rd_data      (rd_data),
        .rd_en        (rd_en),
        .rd_empty     (rd_empty),
        .almost_empty (almost_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Flags packed as {wr_full, almost_full, rd_empty, almost_empty}.
    function automatic logic [7:0] exp_flags(input int occ);
        return {4'b0, occ == 2048, occ >= 1020, occ == 0, occ <= 4};
    endfunction

    // One clock with the given requests; checks rd_data and all flags after the edge.
    task automatic cyc(input logic w, input logic r, input logic [7:0] d, input string tag);
        bit wa, ra;
        wr_en = w; rd_en = r; wr_data = d;
        wa = w && (q.size() < 2048);
        ra = r && (q.size() > 0);
        @(posedge clk); #1;
        if (ra) exp_rd = q.pop_front();
        if (wa) q.push_back(d);
        chk({tag, "_rd"}, rd_data, exp_rd);
        chk({tag, "_flags"}, {4'b0, wr_full, almost_full, rd_empty, almost_empty},
            exp_flags(q.size()));
    endtask

    task automatic do_reset(input int n, input logic w, input logic r);
        rst = 1'b1; wr_en = w; rd_en = r; wr_data = 8'hA5;
        repeat (n) @(posedge clk);
        #1;
        q.delete();
        exp_rd = 8'h00;
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;

        // Reset for 20 cycles; all flags and rd_data take reset values.
        do_reset(20, 1'b0, 1'b0);
        chk("rst_flags", {4'b0, wr_full, almost_full, rd_empty, almost_empty}, 8'h03);
        chk("rst_rd", rd_data, 8'h00);

        // Read while empty is ignored.
        cyc(1'b0, 1'b1, 8'h00, "rd_on_empty");
        chk("rd_on_empty_hold", rd_data, 8'h00);

        // Fill with 0xFF, 0xFE, ... for 2049 cycles; the last write is dropped.
        for (int i = 0; i < 2049; i++) cyc(1'b1, 1'b0, 8'(255 - i), "fill");
        chk("fill_full", {7'b0, wr_full}, 8'h01);

        // Drain for 2049 cycles; first word is 0xFF, last is 0x00, then hold.
        for (int j = 0; j < 2049; j++) begin
            cyc(1'b0, 1'b1, 8'h00, "drain");
            if (j == 0) chk("drain_first", rd_data, 8'hFF);
            if (j == 1) chk("drain_second", rd_data, 8'hFE);
        end
        chk("drain_last_hold", rd_data, 8'h00);
        chk("drain_empty", {7'b0, rd_empty}, 8'h01);

        // Simultaneous read/write while empty: only the write is taken.
        cyc(1'b1, 1'b1, 8'h3C, "empty_rw");
        chk("empty_rw_notempty", {7'b0, rd_empty}, 8'h00);
        chk("empty_rw_rdhold", rd_data, 8'h00);
        cyc(1'b0, 1'b1, 8'h00, "empty_rw_read");
        chk("empty_rw_data", rd_data, 8'h3C);

        // Preload 10 words, then 100 cycles of concurrent read+write.
        for (int k = 0; k < 10; k++) cyc(1'b1, 1'b0, 8'(8'h10 + k), "preload");
        for (int k = 0; k < 100; k++) begin
            cyc(1'b1, 1'b1, 8'(8'h40 + k), "concurrent");
            if (k == 0) chk("concurrent_first", rd_data, 8'h10);
        end
        chk("concurrent_steady", {4'b0, wr_full, almost_full, rd_empty, almost_empty}, 8'h00);
        for (int k = 0; k < 10; k++) cyc(1'b0, 1'b1, 8'h00, "conc_drain");
        chk("conc_drain_last", rd_data, 8'(8'h40 + 99));

        // Refill to full, then read+write together: read wins, write dropped.
        for (int k = 0; k < 2048; k++) cyc(1'b1, 1'b0, 8'(k * 3), "refill");
        cyc(1'b1, 1'b1, 8'hEE, "full_rw");
        chk("full_rw_data", rd_data, 8'h00);
        chk("full_rw_flags", {4'b0, wr_full, almost_full, rd_empty, almost_empty}, 8'h04);

        // Drain to half-full, then reset with a concurrent write request.
        for (int k = 0; k < 1023; k++) cyc(1'b0, 1'b1, 8'h00, "half");
        chk("half_flags", {4'b0, wr_full, almost_full, rd_empty, almost_empty}, 8'h04);
        do_reset(1, 1'b1, 1'b1);
        chk("midrst_flags", {4'b0, wr_full, almost_full, rd_empty, almost_empty}, 8'h03);
        chk("midrst_rd", rd_data, 8'h00);
        cyc(1'b0, 1'b1, 8'h00, "post_rst_rd");
        cyc(1'b1, 1'b0, 8'h77, "post_rst_wr");
        cyc(1'b0, 1'b1, 8'h00, "post_rst_rd2");
        chk("post_rst_data", rd_data, 8'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
